// File: rtl/ltc2601_x4_spi_pkg.sv
// Shared types and constants for the four-channel LTC2601 daisy-chain SPI driver.
// Holds the FSM state encoding, the frame geometry and the DAC command word layout.
package ltc2601_x4_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_CSHIGH = 2'd3
  } state_e;

  localparam int WORD_W = 32;
  localparam int NUM_CH = 4;

  localparam logic [3:0]  CMD_WRU   = 4'h3;
  localparam logic [3:0]  CMD_NOP   = 4'hF;
  localparam logic [15:0] INIT_CODE = 16'h8000;

  // Command word layout: {8'h00, cmd[3:0], 4'h0, data[15:0]}
  function automatic logic [WORD_W-1:0] make_word(input logic [3:0] cmd, input logic [15:0] data);
    return {8'h00, cmd, 4'h0, data};
  endfunction

endpackage

// File: rtl/ltc2601_x4_spi_if.sv
// Host-side word fetch interface of the LTC2601 chain driver.
// trig is a level request sampled only while idle; word must reflect channel addr until the
// driver pulses flush for one cycle, which marks that word as consumed; busy spans the frame.
interface ltc2601_x4_spi_if;
  import ltc2601_x4_spi_pkg::*;

  logic              trig;
  logic [WORD_W-1:0] word;
  logic [3:0]        addr;
  logic              busy;
  logic              flush;

  modport master (output trig, word, input addr, busy, flush);
  modport slave  (input trig, word, output addr, busy, flush);

endinterface

// File: rtl/ltc2601_x4_spi.sv
// Serialises four 32-bit command words (channel 3 first) to a chain of LTC2601 DACs.
// Each word is fetched just in time, shifted MSB first, and the frame ends with a CS/LD high gap.
module ltc2601_x4_spi
  import ltc2601_x4_spi_pkg::*;
#(
  parameter int CLK_DIV        = 4,
  parameter int CS_HIGH_CYCLES = 4
) (
  input  logic            clkin,
  input  logic            reset,
  ltc2601_x4_spi_if.slave bus,
  output logic            sclk,
  output logic            csel,
  output logic            mosi,
  output state_e          dbg_state_o
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(WORD_W);
  localparam int CS_W  = $clog2(CS_HIGH_CYCLES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(WORD_W - 1);
  localparam logic [CS_W-1:0]  CS_LAST  = CS_W'(CS_HIGH_CYCLES - 1);
  localparam logic [3:0]       CH_LAST  = 4'(NUM_CH - 1);

  state_e            state_q, state_d;
  logic [3:0]        addr_q, addr_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  div_nxt;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [CS_W-1:0]   cs_cnt_q, cs_cnt_d;
  logic              sclk_q, sclk_d;
  logic              csel_q, csel_d;
  logic              busy_q, busy_d;
  logic              flush_q, flush_d;

  assign div_nxt = div_q + 1'b1;

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      shreg_q  <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      cs_cnt_q <= '0;
      sclk_q   <= 1'b0;
      csel_q   <= 1'b1;
      busy_q   <= 1'b0;
      flush_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      shreg_q  <= shreg_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      cs_cnt_q <= cs_cnt_d;
      sclk_q   <= sclk_d;
      csel_q   <= csel_d;
      busy_q   <= busy_d;
      flush_q  <= flush_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    shreg_d  = shreg_q;
    div_d    = div_q;
    bit_d    = bit_q;
    cs_cnt_d = cs_cnt_q;
    sclk_d   = 1'b0;
    csel_d   = csel_q;
    busy_d   = busy_q;
    flush_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.trig) begin
          state_d = ST_LOAD;
          busy_d  = 1'b1;
          csel_d  = 1'b0;
          addr_d  = CH_LAST;
        end
      end
      ST_LOAD: begin
        // The capture edge also opens the first bit period, so mosi shows the MSB immediately.
        shreg_d = bus.word;
        state_d = ST_SHIFT;
        div_d   = '0;
        bit_d   = BIT_MSB;
        flush_d = 1'b1;
      end
      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          shreg_d = shreg_q << 1;
          if (bit_q == '0) begin
            if (addr_q == '0) begin
              state_d  = ST_CSHIGH;
              csel_d   = 1'b1;
              cs_cnt_d = '0;
            end else begin
              addr_d  = addr_q - 4'd1;
              state_d = ST_LOAD;
            end
          end else begin
            bit_d = bit_q - 1'b1;
          end
        end else begin
          div_d  = div_nxt;
          sclk_d = (div_nxt >= DIV_HALF);
        end
      end
      ST_CSHIGH: begin
        if (cs_cnt_q == CS_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cs_cnt_d = cs_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.addr    = addr_q;
  assign bus.busy    = busy_q;
  assign bus.flush   = flush_q;
  assign sclk        = sclk_q;
  assign csel        = csel_q;
  assign mosi        = shreg_q[WORD_W-1];
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ltc2601_x4_spi.sv
// Self-checking bench for ltc2601_x4_spi: table-driven frames, random frames and corner sequences.
// A negedge monitor decodes the SPI stream and compares it against an expected-word queue.
module tb_ltc2601_x4_spi;
  import ltc2601_x4_spi_pkg::*;

  localparam int CLK_DIV        = 4;
  localparam int CS_HIGH_CYCLES = 4;
  localparam int FRAME_CSEL     = NUM_CH * (1 + WORD_W * CLK_DIV);
  localparam int FRAME_BUSY     = FRAME_CSEL + CS_HIGH_CYCLES;
  localparam int FRAME_SCLK_HI  = NUM_CH * WORD_W * (CLK_DIV / 2);
  localparam int N_VEC          = 5;

  typedef struct {
    logic [3:0][31:0] w;
    int               csel_low;
    int               busy_len;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b0;
  logic   sclk, csel, mosi;
  state_e dbg_state;

  ltc2601_x4_spi_if bus();

  ltc2601_x4_spi #(.CLK_DIV(CLK_DIV), .CS_HIGH_CYCLES(CS_HIGH_CYCLES)) dut (
    .clkin      (clk),
    .reset      (rst),
    .bus        (bus),
    .sclk       (sclk),
    .csel       (csel),
    .mosi       (mosi),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Word source: the host presents ch_mem[addr] just in time.
  logic [31:0] ch_mem [4];
  always @(negedge clk) bus.word = ch_mem[bus.addr[1:0]];

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [3:0]  flush_addr_q[$];
  int          rise_q[$];
  int          fall_q[$];
  int          cyc = 0;
  int          csel_low_cnt, busy_cnt, sclk_hi_cnt, flush_wide, rx_bits;
  logic [31:0] rx_shift;
  logic        prev_sclk = 1'b0, prev_flush = 1'b0, prev_busy = 1'b0, prev_mosi = 1'b0;
  logic        mon_en = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (!csel) csel_low_cnt++;
      if (bus.busy) busy_cnt++;
      if (sclk) sclk_hi_cnt++;
      if (bus.flush) begin
        flush_addr_q.push_back(bus.addr);
        if (prev_flush) flush_wide++;
      end
      if (bus.busy && !prev_busy) rise_q.push_back(cyc);
      if (!bus.busy && prev_busy) fall_q.push_back(cyc);
      if (sclk && prev_sclk) check("mosi_stable_while_sclk_high", 32'(mosi), 32'(prev_mosi));
      if (csel) begin
        rx_bits = 0;
      end else if (sclk && !prev_sclk) begin
        rx_shift = {rx_shift[30:0], mosi};
        rx_bits++;
        if (rx_bits == WORD_W) begin
          rx_bits = 0;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx_unexpected_word: got 0x%08h, required no word", rx_shift);
          end else begin
            check("rx_word", rx_shift, exp_q.pop_front());
          end
        end
      end
    end
    prev_sclk  = sclk;
    prev_flush = bus.flush;
    prev_busy  = bus.busy;
    prev_mosi  = mosi;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    bus.trig = 1'b0;
    tick(3);
    rst = 1'b0;
  endtask

  task automatic clear_mon();
    csel_low_cnt = 0;
    busy_cnt     = 0;
    sclk_hi_cnt  = 0;
    flush_wide   = 0;
    flush_addr_q.delete();
    rise_q.delete();
    fall_q.delete();
  endtask

  // Model: a frame carries the current words of channels 3,2,1,0 in that order.
  task automatic push_frame_model();
    for (int c = NUM_CH - 1; c >= 0; c--) exp_q.push_back(ch_mem[c]);
  endtask

  task automatic start_frame();
    push_frame_model();
    bus.trig = 1'b1;
    tick(1);
    bus.trig = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int k = 0;
    while (bus.busy && k < max_cyc) begin
      tick(1);
      k++;
    end
    if (bus.busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL busy_timeout: busy=1 after %0d cycles, required 0", max_cyc);
    end
  endtask

  task automatic check_frame(input int exp_csel, input int exp_busy, input int frames);
    check("csel_low_cycles", 32'(csel_low_cnt), 32'(exp_csel));
    check("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
    check("sclk_high_cycles", 32'(sclk_hi_cnt), 32'(FRAME_SCLK_HI * frames));
    check("flush_count", 32'(flush_addr_q.size()), 32'(NUM_CH * frames));
    check("flush_wide", 32'(flush_wide), 32'd0);
    for (int i = 0; i < flush_addr_q.size(); i++)
      check("flush_addr", 32'(flush_addr_q[i]), 32'(NUM_CH - 1 - (i % NUM_CH)));
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs [N_VEC];

  initial begin
    bus.trig = 1'b0;
    for (int c = 0; c < NUM_CH; c++) ch_mem[c] = '0;

    vecs[0].w[3] = 32'h0030_4000; vecs[0].w[2] = 32'h0030_8000;
    vecs[0].w[1] = 32'h0030_C000; vecs[0].w[0] = 32'h0030_FFFF;
    for (int c = 0; c < NUM_CH; c++) vecs[1].w[c] = make_word(CMD_WRU, INIT_CODE);
    for (int c = 0; c < NUM_CH; c++) vecs[2].w[c] = make_word(CMD_NOP, 16'h0000);
    vecs[3].w[3] = 32'hFFFF_FFFF; vecs[3].w[2] = 32'h0000_0000;
    vecs[3].w[1] = 32'hAAAA_AAAA; vecs[3].w[0] = 32'h5555_5555;
    for (int c = 0; c < NUM_CH; c++) vecs[4].w[c] = $urandom;
    for (int i = 0; i < N_VEC; i++) begin
      vecs[i].csel_low = FRAME_CSEL;
      vecs[i].busy_len = FRAME_BUSY;
    end

    // Reset and idle
    do_reset();
    mon_en = 1'b1;
    clear_mon();
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("idle_csel", 32'(csel), 32'd1);
      check("idle_sclk", 32'(sclk), 32'd0);
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_flush", 32'(bus.flush), 32'd0);
      check("idle_addr", 32'(bus.addr), 32'd0);
      check("idle_mosi", 32'(mosi), 32'd0);
      check("idle_state", 32'(dbg_state), 32'(ST_IDLE));
    end

    // Table-driven frames
    for (int i = 0; i < N_VEC; i++) begin
      for (int c = 0; c < NUM_CH; c++) ch_mem[c] = vecs[i].w[c];
      clear_mon();
      start_frame();
      wait_idle(FRAME_BUSY + 50);
      tick(3);
      check_frame(vecs[i].csel_low, vecs[i].busy_len, 1);
      check("end_addr", 32'(bus.addr), 32'd0);
    end

    // Random frames with random gaps
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < NUM_CH; c++) ch_mem[c] = $urandom;
      clear_mon();
      start_frame();
      wait_idle(FRAME_BUSY + 50);
      tick(3 + $urandom_range(0, 5));
      check_frame(FRAME_CSEL, FRAME_BUSY, 1);
    end

    // Level trig held: two back-to-back frames with one idle cycle between them
    for (int c = 0; c < NUM_CH; c++) ch_mem[c] = $urandom;
    clear_mon();
    push_frame_model();
    push_frame_model();
    bus.trig = 1'b1;
    tick(600);
    bus.trig = 1'b0;
    wait_idle(FRAME_BUSY + 50);
    tick(3);
    check_frame(2 * FRAME_CSEL, 2 * FRAME_BUSY, 2);
    check("hold_rise_count", 32'(rise_q.size()), 32'd2);
    check("hold_fall_count", 32'(fall_q.size()), 32'd2);
    if (rise_q.size() >= 2 && fall_q.size() >= 1) begin
      check("hold_first_busy_len", 32'(fall_q[0] - rise_q[0]), 32'(FRAME_BUSY));
      check("hold_gap_cycles", 32'(rise_q[1] - fall_q[0]), 32'd1);
    end

    // Reset at cycle 200 of a frame
    for (int c = 0; c < NUM_CH; c++) ch_mem[c] = $urandom;
    clear_mon();
    start_frame();
    tick(199);
    rst = 1'b1;
    tick(1);
    check("abort_csel", 32'(csel), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_flush", 32'(bus.flush), 32'd0);
    check("abort_addr", 32'(bus.addr), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    check("abort_words_left", 32'(exp_q.size()), 32'(NUM_CH - 1));
    check("abort_flush_before", 32'(flush_addr_q.size()), 32'd2);
    exp_q.delete();
    tick(200);
    check("abort_no_new_flush", 32'(flush_addr_q.size()), 32'd2);
    check("abort_still_idle", 32'(bus.busy), 32'd0);

    // Changing channel 3's word after it is captured does not alter the frame
    ch_mem[3] = 32'h0030_1234; ch_mem[2] = 32'h0030_5678;
    ch_mem[1] = 32'h0030_9ABC; ch_mem[0] = 32'h0030_DEF0;
    clear_mon();
    start_frame();
    begin
      int k = 0;
      while (!(bus.flush && bus.addr == 4'd3) && k < 50) begin
        tick(1);
        k++;
      end
      check("ch3_flush_seen", 32'(bus.flush && bus.addr == 4'd3), 32'd1);
    end
    tick(10);
    ch_mem[3] = 32'hFFCF_EDCB;
    wait_idle(FRAME_BUSY + 50);
    tick(3);
    check_frame(FRAME_CSEL, FRAME_BUSY, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
